// File: rtl/signal_sync_filter_pkg.sv
// Shared constants and helpers for clock-domain-crossing input blocks.
// Provides the default synchroniser depth and a constant-foldable clog2.
package signal_sync_filter_pkg;

  localparam int SYNC_STAGES_DEFAULT = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/signal_debounce_ch.sv
// One channel of the input conditioner: stability counter, filtered level
// register and registered one-cycle rise/fall pulses.
module signal_debounce_ch #(
  parameter int   FILTER    = 4,
  parameter int   CNT_W     = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic syncIn,
  output logic level,
  output logic rise,
  output logic fall,
  output logic pulseNext
);

  logic [CNT_W-1:0] cnt;
  logic             differs;

  assign differs   = syncIn != level;
  assign pulseNext = differs && (cnt == CNT_W'(FILTER - 1));

  // Count consecutive cycles of disagreement; adopt the new level once stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= RESET_VAL;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (!differs) begin
        cnt <= '0;
      end else if (pulseNext) begin
        level <= syncIn;
        cnt   <= '0;
        rise  <= syncIn;
        fall  <= !syncIn;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/signal_sync_filter.sv
// N-channel synchroniser plus debounce filter with edge pulses.
// Holds the synchroniser chain and the changed OR-reduction.
module signal_sync_filter
  import signal_sync_filter_pkg::*;
#(
  parameter int           N         = 1,
  parameter int           STAGES    = SYNC_STAGES_DEFAULT,
  parameter int           FILTER    = 4,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] async_in,
  output logic [N-1:0] sync_out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         changed
);

  localparam int CNT_W = (clog2(FILTER) < 1) ? 1 : clog2(FILTER);

  (* ASYNC_REG = "TRUE", shreg_extract = "no" *)
  logic [N-1:0] syncStage [STAGES];

  logic [N-1:0] pulseNext;

  // Plain flop chain; nothing but wires between stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) syncStage[k] <= RESET_VAL;
    end else begin
      syncStage[0] <= async_in;
      for (int k = 1; k < STAGES; k++) syncStage[k] <= syncStage[k-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : gCh
    signal_debounce_ch #(
      .FILTER   (FILTER),
      .CNT_W    (CNT_W),
      .RESET_VAL(RESET_VAL[i])
    ) uCh (
      .clk      (clk),
      .rst      (rst),
      .syncIn   (syncStage[STAGES-1][i]),
      .level    (sync_out[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .pulseNext(pulseNext[i])
    );
  end

  // Registered from next-cycle pulse terms so it lines up with rise/fall.
  always_ff @(posedge clk) begin
    if (rst) changed <= 1'b0;
    else     changed <= |pulseNext;
  end

endmodule
